fadd32_arb: RTL and testbench
=============================

FADD32_ARB -- requirements
Module: fadd32_arb

Interface
REQ-001 SHALL have parameter LAT, default 3, meaning adder cycles from operand-register load to fa_res sampled (legal 1..8).
REQ-002 SHALL have parameter RSP_DEPTH, default 4, meaning per-requester response FIFO depth (power of two, 2..16).
REQ-003 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-004 SHALL have, for i in {0,1}: reqi_valid in 1; reqi_ready out 1; reqi_mode in 1 (0 add, 1 sub); reqi_a in 32; reqi_b in 32.
REQ-005 SHALL have adder side: fa_mode out 1; fa_a out 32; fa_b out 32; fa_res in 32.
REQ-006 SHALL have, for i in {0,1}: rspi_valid out 1; rspi_ready in 1; rspi_data out 32.
REQ-007 SHALL have busy out 1: any operation in flight or any FIFO non-empty.

Function
REQ-008 SHALL track outi = in-flight ops of requester i + FIFO i occupancy, range 0..RSP_DEPTH.
REQ-009 SHALL mark requester i eligible when reqi_valid=1 and outi<RSP_DEPTH.
REQ-010 SHALL grant at most one requester per cycle, round-robin: with both eligible, grant the one not granted last; with one eligible, grant it.
REQ-011 SHALL drive reqi_ready=1 exactly when requester i is granted this cycle (combinational from valids and counters); transfer = valid&ready.
REQ-012 SHALL update the last-grant pointer only on a transfer.
REQ-013 SHALL load fa_mode/fa_a/fa_b registers with the granted request on the transfer edge and hold them otherwise.
REQ-014 SHALL carry a LAT-stage valid+id shift pipeline; fa_res SHALL be written into FIFO id exactly LAT edges after the transfer edge.
REQ-015 SHALL accept back-to-back transfers every cycle; results return in issue order per requester.
REQ-016 SHALL present FIFO i head on rspi_data with rspi_valid=1 when non-empty; pop on rspi_valid&rspi_ready.
REQ-017 SHALL keep outi unchanged when transfer and pop of requester i occur in the same cycle; +1 on transfer only, -1 on pop only.
REQ-018 SHALL never overflow a FIFO (guaranteed by REQ-009); write and pop of the same FIFO in one cycle SHALL both take effect, including when full.
REQ-019 SHALL hold reqi_ready=0 while outi=RSP_DEPTH, regardless of reqi_valid.
REQ-020 SHALL keep operand and response data stable while held; wrap-around of FIFO pointers modulo RSP_DEPTH.

Reset
REQ-021 SHALL on rst_n=0 immediately clear: pipeline valids, FIFO pointers, outi, pointer (next tie to requester 0), fa_mode/fa_a/fa_b=0.
REQ-022 SHALL drive during reset: req0_ready=req1_ready=0, rsp0_valid=rsp1_valid=0, rspi_data=0, busy=0.
REQ-023 SHALL discard all in-flight operations on reset mid-operation; no result SHALL appear after reset release without a new transfer.

Configuration
REQ-024 SHALL, with FADD32_ARB_STATS_EN defined, add outputs stat0_cnt out 16, stat1_cnt out 16 (saturating transfer counts) and stall_cnt out 16 (saturating cycles with a valid request and no transfer), all reset to 0.
REQ-025 SHALL, without FADD32_ARB_STATS_EN, omit those ports and counters entirely.

Verification (bench adder model: fa_res = IEEE-754 single result of registered operands, delayed per LAT)
REQ-026 Single op: req0 a=0x3F800000 b=0x40000000 mode=0 -> rsp0_data=0x40400000 valid LAT cycles after transfer edge.
REQ-027 Contention: both valid every cycle, rsp ready=1 -> grants alternate 0,1,0,1; first tie after reset goes to 0; throughput 1/cycle.
REQ-028 Backpressure: rsp1_ready=0, req1 valid continuously, RSP_DEPTH=4 -> exactly 4 transfers then req1_ready=0; req0 still served; one pop re-enables one transfer.
REQ-029 Full+simultaneous: FIFO0 full, pop and new write same cycle -> occupancy stays 4, order preserved, no data lost.
REQ-030 Reset mid-flight: assert rst_n=0 with 3 ops in flight -> rspi_valid=0, busy=0 immediately, no results after release.
REQ-031 Stats: FADD32_ARB_STATS_EN on, 70000 req0 transfers -> stat0_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/fadd32_arb.sv
// fadd32_arb: two-requester round-robin front end for a shared, externally
// pipelined 32-bit floating-point adder, with one response FIFO per requester.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   reqN_valid/ready/mode/a/b        request channel N (mode 0 add, 1 sub);
//                                    reqN_ready is combinational (grant)
//   fa_mode, fa_a, fa_b              registered operands to the adder
//   fa_res                           adder result, LAT edges after load
//   rspN_valid/ready/data            response channel N (FIFO head)
//   busy                             any op in flight or any FIFO non-empty
//   stat0_cnt, stat1_cnt, stall_cnt  saturating counters, present only when
//                                    FADD32_ARB_STATS_EN is defined
//
// Parameters: LAT (1..8) adder latency, RSP_DEPTH (power of two, 2..16).
`timescale 1ns/1ps
module fadd32_arb #(
  parameter int unsigned LAT       = 3,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_mode,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_mode,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        fa_mode,
  output logic [31:0] fa_a,
  output logic [31:0] fa_b,
  input  logic [31:0] fa_res,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        busy
`ifdef FADD32_ARB_STATS_EN
  ,
  output logic [15:0] stat0_cnt,
  output logic [15:0] stat1_cnt,
  output logic [15:0] stall_cnt
`endif
);
  localparam int unsigned DW = 32;
  localparam int unsigned PW = $clog2(RSP_DEPTH);
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  logic [1:0]    req_valid, req_mode, rsp_ready;
  logic [1:0]    elig, gnt, pop, wr;
  logic [DW-1:0] req_a [2];
  logic [DW-1:0] req_b [2];

  logic          last_q;           // requester granted on the most recent transfer
  logic [LAT-1:0] pv_q, pid_q;     // adder pipeline valid / requester id
  logic [CW-1:0] out_q [2];        // in-flight + queued per requester
  logic [CW-1:0] cnt_q [2];        // FIFO occupancy
  logic [PW-1:0] wp_q [2];
  logic [PW-1:0] rp_q [2];
  logic [DW-1:0] mem_q [2][RSP_DEPTH];

  assign req_valid = {req1_valid, req0_valid};
  assign req_mode  = {req1_mode, req0_mode};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_a[0]  = req0_a;
  assign req_a[1]  = req1_a;
  assign req_b[0]  = req0_b;
  assign req_b[1]  = req1_b;

  // Eligibility, round-robin grant, FIFO write/pop strobes.
  always_comb begin
    elig = '0;
    pop  = '0;
    wr   = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = rst_n && req_valid[i] && (out_q[i] < CW'(RSP_DEPTH));
      pop[i]  = (cnt_q[i] != '0) && rsp_ready[i];
      wr[i]   = pv_q[LAT-1] && (pid_q[LAT-1] == 1'(i));
    end
    gnt[0] = elig[0] && (!elig[1] || last_q);
    gnt[1] = elig[1] && (!elig[0] || !last_q);
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign rsp0_valid = (cnt_q[0] != '0);
  assign rsp1_valid = (cnt_q[1] != '0);
  // Data is masked while empty so it reads zero during and after reset.
  assign rsp0_data  = rsp0_valid ? mem_q[0][rp_q[0]] : '0;
  assign rsp1_data  = rsp1_valid ? mem_q[1][rp_q[1]] : '0;
  assign busy       = (out_q[0] != '0) || (out_q[1] != '0);

  // Operand registers, grant pointer and adder tracking pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= 1'b1;
      fa_mode <= 1'b0;
      fa_a    <= '0;
      fa_b    <= '0;
      pv_q    <= '0;
      pid_q   <= '0;
    end else begin
      pv_q[0]  <= |gnt;
      pid_q[0] <= gnt[1];
      for (int s = 1; s < LAT; s++) begin
        pv_q[s]  <= pv_q[s-1];
        pid_q[s] <= pid_q[s-1];
      end
      if (|gnt) begin
        last_q  <= gnt[1];
        fa_mode <= gnt[1] ? req_mode[1] : req_mode[0];
        fa_a    <= gnt[1] ? req_a[1] : req_a[0];
        fa_b    <= gnt[1] ? req_b[1] : req_b[0];
      end
    end
  end

  // Outstanding counters and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        out_q[i] <= '0;
        cnt_q[i] <= '0;
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (gnt[i] && !pop[i])      out_q[i] <= out_q[i] + CW'(1);
        else if (!gnt[i] && pop[i]) out_q[i] <= out_q[i] - CW'(1);
        if (wr[i] && !pop[i])       cnt_q[i] <= cnt_q[i] + CW'(1);
        else if (!wr[i] && pop[i])  cnt_q[i] <= cnt_q[i] - CW'(1);
        if (wr[i])  wp_q[i] <= wp_q[i] + PW'(1);
        if (pop[i]) rp_q[i] <= rp_q[i] + PW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr[i]) mem_q[i][wp_q[i]] <= fa_res;
    end
  end

`ifdef FADD32_ARB_STATS_EN
  // Saturating transfer and stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat0_cnt <= '0;
      stat1_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (gnt[0] && (stat0_cnt != 16'hFFFF)) stat0_cnt <= stat0_cnt + 16'd1;
      if (gnt[1] && (stat1_cnt != 16'hFFFF)) stat1_cnt <= stat1_cnt + 16'd1;
      if ((|req_valid) && !(|gnt) && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fadd32_arb.sv
// Scoreboard bench for fadd32_arb: expected results are queued per requester
// at each transfer and checked by a monitor whenever a response pops.
`timescale 1ns/1ps
module tb_fadd32_arb;
  localparam int unsigned LAT = 3;
`ifdef FADD32_ARB_STATS_EN
  localparam int unsigned RSP_DEPTH = 8;
`else
  localparam int unsigned RSP_DEPTH = 4;
`endif

  localparam logic [31:0] TA [8] = '{32'h3F800000, 32'h40A00000, 32'h3F000000, 32'h3F800000,
                                     32'hBF800000, 32'h40000000, 32'h3F800000, 32'h3FC00000};
  localparam logic [31:0] TB [8] = '{32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F800000,
                                     32'h40800000, 32'h40800000, 32'h40800000, 32'h3F000000};
  localparam logic        TM [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [31:0] TE [8] = '{32'h40400000, 32'h40400000, 32'h3F800000, 32'h00000000,
                                     32'h40400000, 32'h40C00000, 32'hC0400000, 32'h40000000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_mode, rsp_ready;
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [31:0] req_exp [2];
  wire  [1:0]  req_ready, rsp_valid;
  wire  [31:0] rsp_data [2];
  wire         fa_mode, busy;
  wire  [31:0] fa_a, fa_b, fa_res;
`ifdef FADD32_ARB_STATS_EN
  wire  [15:0] stat0_cnt, stat1_cnt, stall_cnt;
`endif

  int          n_check = 0;
  int          n_pass  = 0;
  int          n_xfer [2] = '{0, 0};
  logic [1:0]  xfer;
  logic [31:0] exp0_q [$];
  logic [31:0] exp1_q [$];

  always #5 clk = ~clk;

  fadd32_arb #(.LAT(LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_mode(req_mode[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_mode(req_mode[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]),
    .fa_mode(fa_mode), .fa_a(fa_a), .fa_b(fa_b), .fa_res(fa_res),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_data(rsp_data[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_data(rsp_data[1]),
    .busy(busy)
`ifdef FADD32_ARB_STATS_EN
    , .stat0_cnt(stat0_cnt), .stat1_cnt(stat1_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Exact float <-> real conversion for normal, exactly representable values.
  function automatic real b2r(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2b(input real v);
    logic        s;
    int          e;
    real         m;
    logic [22:0] f;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, 8'(e), f};
  endfunction

  function automatic logic [31:0] fadd_m(input logic [31:0] a, input logic [31:0] b, input logic sub);
    real rb;
    rb = b2r(b);
    if (sub) rb = -rb;
    return r2b(b2r(a) + rb);
  endfunction

  // Adder model: combinational result of the operand registers, LAT-1 flops deep.
  logic [31:0] mdl_c;
  always_comb mdl_c = fadd_m(fa_a, fa_b, fa_mode);
  if (LAT == 1) begin : g_l1
    assign fa_res = mdl_c;
  end else begin : g_ln
    logic [31:0] dly [LAT-1];
    always @(posedge clk) begin
      dly[0] <= mdl_c;
      for (int k = 1; k < LAT - 1; k++) dly[k] <= dly[k-1];
    end
    assign fa_res = dly[LAT-2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every pop is compared with the oldest expected result.
  always @(negedge clk) begin
    if (rsp_valid[0] && rsp_ready[0]) begin
      if (exp0_q.size() == 0) begin
        n_check++;
        $display("FAIL rsp0_unexpected: got 0x%08h expected no response", rsp_data[0]);
      end else check("rsp0_data", rsp_data[0], exp0_q.pop_front());
    end
    if (rsp_valid[1] && rsp_ready[1]) begin
      if (exp1_q.size() == 0) begin
        n_check++;
        $display("FAIL rsp1_unexpected: got 0x%08h expected no response", rsp_data[1]);
      end else check("rsp1_data", rsp_data[1], exp1_q.pop_front());
    end
  end

  // One clock: record transfers before the edge, return just after it.
  task automatic cycle();
    @(negedge clk);
    xfer = req_valid & req_ready;
    if (xfer[0]) begin exp0_q.push_back(req_exp[0]); n_xfer[0]++; end
    if (xfer[1]) begin exp1_q.push_back(req_exp[1]); n_xfer[1]++; end
    @(posedge clk);
    #1;
  endtask

  task automatic load_gen(input int i);
    if (i == 0) begin
      req_a[0] = r2b(real'(n_xfer[0] % 100 + 1));
      req_b[0] = 32'h40000000;
      req_mode[0] = 1'b0;
      req_exp[0] = r2b(real'(n_xfer[0] % 100 + 3));
    end else begin
      req_a[1] = r2b(real'(n_xfer[1] % 100 + 50));
      req_b[1] = 32'h3F800000;
      req_mode[1] = 1'b1;
      req_exp[1] = r2b(real'(n_xfer[1] % 100 + 49));
    end
  endtask

  task automatic gen_step();
    if (xfer[0]) load_gen(0);
    if (xfer[1]) load_gen(1);
  endtask

  task automatic drain();
    int c;
    req_valid = '0;
    rsp_ready = 2'b11;
    c = 0;
    while (busy && c < 200) begin cycle(); c++; end
    check("drain_idle", 32'(busy), 32'd0);
    check("drain_q0_empty", 32'(exp0_q.size()), 32'd0);
    check("drain_q1_empty", 32'(exp1_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    exp0_q.delete();
    exp1_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, idx, n0s, n1s;
    logic seen;
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_mode = '0;
    rsp_ready = 2'b11;
    load_gen(0);
    load_gen(1);
    #12;
    check("rst_req0_ready", 32'(req_ready[0]), 32'd0);
    check("rst_req1_ready", 32'(req_ready[1]), 32'd0);
    check("rst_rsp0_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_rsp1_valid", 32'(rsp_valid[1]), 32'd0);
    check("rst_rsp0_data", rsp_data[0], 32'd0);
    check("rst_rsp1_data", rsp_data[1], 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fa_a", fa_a, 32'd0);
    check("rst_fa_b", fa_b, 32'd0);
    check("rst_fa_mode", 32'(fa_mode), 32'd0);
    do_reset();

    // Single op 1.0 + 2.0 and its latency.
    req_a[0] = 32'h3F800000; req_b[0] = 32'h40000000; req_mode[0] = 1'b0;
    req_exp[0] = 32'h40400000;
    req_valid = 2'b01;
    cycle();
    check("single_xfer", 32'(xfer), 32'd1);
    req_valid = '0;
    lat = 0;
    for (int k = 1; k <= 4 * LAT + 4; k++) begin
      @(posedge clk); #1;
      if (rsp_valid[0]) begin lat = k; break; end
    end
    check("single_latency", 32'(lat), 32'(LAT));
    drain();

    // Directed table back-to-back on requester 0.
    idx = 0;
    req_a[0] = TA[0]; req_b[0] = TB[0]; req_mode[0] = TM[0]; req_exp[0] = TE[0];
    req_valid = 2'b01;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      cycle();
      if (xfer[0]) begin
        idx++;
        if (idx < 8) begin
          req_a[0] = TA[idx]; req_b[0] = TB[idx]; req_mode[0] = TM[idx]; req_exp[0] = TE[idx];
        end else req_valid = '0;
      end
    end
    check("table_all_issued", 32'(idx), 32'd8);
    drain();

    // Contention: strict alternation from requester 0 after reset.
    do_reset();
    load_gen(0); load_gen(1);
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("contention_grant", 32'(xfer), (k % 2 == 0) ? 32'd1 : 32'd2);
      gen_step();
    end
    drain();

    // Backpressure on requester 1.
    rsp_ready = 2'b01;
    load_gen(0); load_gen(1);
    req_valid = 2'b11;
    n0s = n_xfer[0]; n1s = n_xfer[1];
    for (int k = 0; k < 4 * int'(RSP_DEPTH); k++) begin cycle(); gen_step(); end
    check("bp_req1_xfers", 32'(n_xfer[1] - n1s), 32'(RSP_DEPTH));
    check("bp_req0_served", 32'(n_xfer[0] - n0s >= 2 * int'(RSP_DEPTH)), 32'd1);
    check("bp_req1_ready_low", 32'(req_ready[1]), 32'd0);
    check("bp_rsp1_valid", 32'(rsp_valid[1]), 32'd1);
    req_valid = 2'b10;
    n1s = n_xfer[1];
    rsp_ready = 2'b11;
    cycle(); gen_step();
    rsp_ready = 2'b01;
    for (int k = 0; k < 6; k++) begin cycle(); gen_step(); end
    check("bp_one_pop_one_xfer", 32'(n_xfer[1] - n1s), 32'd1);
    drain();

    // Fill FIFO0, then stream with simultaneous write/pop.
    rsp_ready = 2'b10;
    load_gen(0);
    req_valid = 2'b01;
    n0s = n_xfer[0];
    for (int k = 0; k < 2 * int'(RSP_DEPTH) + int'(LAT); k++) begin cycle(); gen_step(); end
    check("full_xfers", 32'(n_xfer[0] - n0s), 32'(RSP_DEPTH));
    check("full_req0_ready_low", 32'(req_ready[0]), 32'd0);
    check("full_rsp0_valid", 32'(rsp_valid[0]), 32'd1);
    rsp_ready = 2'b11;
    for (int k = 0; k < 3 * int'(RSP_DEPTH); k++) begin cycle(); gen_step(); end
    drain();

    // Reset with three ops in flight.
    load_gen(0); load_gen(1);
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin cycle(); gen_step(); end
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rsp0_valid", 32'(rsp_valid[0]), 32'd0);
    check("mid_rsp1_valid", 32'(rsp_valid[1]), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_req0_ready", 32'(req_ready[0]), 32'd0);
    exp0_q.delete();
    exp1_q.delete();
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (|rsp_valid) seen = 1'b1;
    end
    check("mid_no_results", 32'(seen), 32'd0);
    check("mid_idle", 32'(busy), 32'd0);

`ifdef FADD32_ARB_STATS_EN
    do_reset();
    req_a[0] = 32'h3F800000; req_b[0] = 32'h40000000; req_mode[0] = 1'b0;
    req_exp[0] = 32'h40400000;
    req_valid = 2'b01;
    for (int k = 0; k < 70000; k++) cycle();
    check("stat0_saturated", 32'(stat0_cnt), 32'h0000FFFF);
    check("stat1_zero", 32'(stat1_cnt), 32'd0);
    check("stall_zero", 32'(stall_cnt), 32'd0);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
